// File: rtl/imem_boot_loader_if.sv
// Host byte link plus instruction RAM write port of the boot loader.
// Ports: rx_valid/rx_data/rx_ready byte handshake; wr_en/wr_addr/wr_data RAM write.
interface imem_boot_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot sequencer: receives a framed byte stream, fills instruction RAM, releases the CPU.
// Ports: clk, rst_n (sync), start; bus (slave: byte in, RAM write out); cpu_rst_n, busy, done, error.
module imem_boot_loader #(
    parameter int DEPTH_WORDS    = 256,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    imem_boot_loader_if.slave  bus,
    output logic               cpu_rst_n,
    output logic               busy,
    output logic               done,
    output logic               error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_CSUM, S_RUN, S_ERR
    } state_t;

    state_t state, state_nxt;

    logic [15:0]   count;
    logic [15:0]   widx;
    logic [1:0]    bcnt;
    logic [7:0]    csum;
    logic [23:0]   word;
    logic [TW-1:0] tmo;

    logic          rx_ready_q;
    logic          wr_en_q;
    logic [31:0]   wr_addr_q;
    logic [31:0]   wr_data_q;

    logic          loading;
    logic          acc;
    logic          go;
    logic          tmo_hit;
    logic          hdr_bad;
    logic          last_byte;
    logic [15:0]   n_hdr;

    logic          rdy_d;
    logic          busy_d;
    logic          done_d;
    logic          err_d;
    logic          cpu_d;

    assign bus.rx_ready = rx_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

    assign loading   = state inside {S_HDR_LO, S_HDR_HI, S_DATA, S_CSUM};
    assign acc       = bus.rx_valid && rx_ready_q;
    assign go        = start && (state inside {S_IDLE, S_RUN, S_ERR});
    // Counter holds idle cycles already elapsed; this cycle idle makes it TIMEOUT.
    assign tmo_hit   = (tmo == TW'(TIMEOUT_CYCLES - 1));
    assign n_hdr     = {bus.rx_data, count[7:0]};
    assign hdr_bad   = (n_hdr == 16'd0) ||
                       ({16'd0, n_hdr} > 32'(DEPTH_WORDS));
    assign last_byte = (bcnt == 2'd3) && (widx == count - 16'd1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) state_nxt = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (acc)          state_nxt = S_HDR_HI;
                else if (tmo_hit) state_nxt = S_ERR;
            end
            S_HDR_HI: begin
                if (acc)          state_nxt = hdr_bad ? S_ERR : S_DATA;
                else if (tmo_hit) state_nxt = S_ERR;
            end
            S_DATA: begin
                if (acc) begin
                    if (last_byte) state_nxt = S_CSUM;
                end else if (tmo_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_CSUM: begin
                if (acc)
                    state_nxt = (csum == bus.rx_data) ? S_RUN : S_ERR;
                else if (tmo_hit)
                    state_nxt = S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; taken from the next state so the flops match the state reg
    always_comb begin
        rdy_d  = state_nxt inside {S_HDR_LO, S_HDR_HI, S_DATA, S_CSUM};
        busy_d = rdy_d;
        done_d = (state_nxt == S_RUN);
        err_d  = (state_nxt == S_ERR);
        cpu_d  = (state_nxt == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_ready_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_rst_n  <= 1'b0;
        end else begin
            rx_ready_q <= rdy_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= err_d;
            cpu_rst_n  <= cpu_d;
        end
    end

    // Datapath: header, word assembly, checksum, timeout, RAM write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            widx      <= '0;
            bcnt      <= '0;
            csum      <= '0;
            word      <= '0;
            tmo       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (go) begin
                widx <= '0;
                bcnt <= '0;
                csum <= '0;
                tmo  <= '0;
            end else if (loading) begin
                if (acc) begin
                    tmo <= '0;
                    if (state != S_CSUM) csum <= csum + bus.rx_data;
                    unique case (state)
                        S_HDR_LO: count[7:0]  <= bus.rx_data;
                        S_HDR_HI: count[15:8] <= bus.rx_data;
                        S_DATA: begin
                            bcnt <= bcnt + 2'd1;
                            unique case (bcnt)
                                2'd0: word[7:0]   <= bus.rx_data;
                                2'd1: word[15:8]  <= bus.rx_data;
                                2'd2: word[23:16] <= bus.rx_data;
                                2'd3: begin
                                    wr_en_q   <= 1'b1;
                                    wr_addr_q <= {14'd0, widx, 2'b00};
                                    wr_data_q <= {bus.rx_data, word};
                                    widx      <= widx + 16'd1;
                                end
                            endcase
                        end
                        default: ;
                    endcase
                end else begin
                    tmo <= tmo + TW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader against a frame-level model.
// Drives inputs 1 time unit after rising edges, samples outputs on falling edges.
module tb_imem_boot_loader;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic cpu_rst_n;
    logic busy;
    logic done;
    logic error;

    imem_boot_loader_if bus();

    imem_boot_loader #(
        .DEPTH_WORDS    (256),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus.slave),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write monitor
    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    int          ready_drops;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            got_a.push_back(bus.wr_addr);
            got_d.push_back(bus.wr_data);
        end
        if (busy === 1'b1 && bus.rx_ready !== 1'b1) ready_drops++;
    end

    // Frame-level reference model
    logic [7:0]  frame[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    bit          exp_done;
    bit          exp_err;

    task automatic model();
        int         n;
        int         len;
        logic [7:0] s;
        exp_a.delete();
        exp_d.delete();
        exp_done = 0;
        exp_err  = 0;
        len = frame.size();
        n = {frame[1], frame[0]};
        if (n == 0 || n > 256) begin
            exp_err = 1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (4 * i + 5 < len) begin
                exp_a.push_back(32'(i * 4));
                exp_d.push_back({frame[4*i+5], frame[4*i+4],
                                 frame[4*i+3], frame[4*i+2]});
            end
        end
        if (len < 4 * n + 3) return;
        s = 8'd0;
        for (int i = 0; i < 4 * n + 2; i++) s += frame[i];
        if (s == frame[4*n+2]) exp_done = 1;
        else                   exp_err  = 1;
    endtask

    task automatic build(input int n, input bit corrupt);
        logic [7:0] s;
        logic [15:0] nn;
        nn = 16'(n);
        frame.delete();
        frame.push_back(nn[7:0]);
        frame.push_back(nn[15:8]);
        for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
        s = 8'd0;
        foreach (frame[i]) s += frame[i];
        if (corrupt) s += 8'($urandom_range(255, 1));
        frame.push_back(s);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int budget;
        if (gap > 0) begin
            bus.rx_valid = 1'b0;
            repeat (gap) step();
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        acc    = 0;
        budget = 0;
        while (!acc && budget < 50) begin
            @(negedge clk);
            acc = bus.rx_ready;
            step();
            start = 1'b0;
            budget++;
        end
        if (!acc) check("accept_wait", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input int gap_max, input int start_at);
        for (int i = 0; i < frame.size(); i++) begin
            if (i == start_at) start = 1'b1;
            send_byte(frame[i],
                      gap_max > 0 ? int'($urandom_range(gap_max, 0)) : 0);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic verify(input string tag);
        check({tag, "_nwr"}, 32'(got_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            check({tag, "_addr"}, got_a[i], exp_a[i]);
            check({tag, "_data"}, got_d[i], exp_d[i]);
        end
        @(negedge clk);
        check({tag, "_done"},  32'(done),      32'(exp_done));
        check({tag, "_error"}, 32'(error),     32'(exp_err));
        check({tag, "_cpu"},   32'(cpu_rst_n), 32'(exp_done));
        check({tag, "_busy"},  32'(busy),      32'd0);
        step();
    endtask

    // Start, confirm the restart state, stream the frame, then verify
    task automatic run_case(input string tag, input int gap_max,
                            input int start_at);
        got_a.delete();
        got_d.delete();
        model();
        pulse_start();
        @(negedge clk);
        check({tag, "_st_busy"},  32'(busy),      32'd1);
        check({tag, "_st_done"},  32'(done),      32'd0);
        check({tag, "_st_error"}, 32'(error),     32'd0);
        check({tag, "_st_cpu"},   32'(cpu_rst_n), 32'd0);
        step();
        send_frame(gap_max, start_at);
        repeat (3) step();
        verify(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_rdy"},   32'(bus.rx_ready), 32'd0);
        check({tag, "_wren"},  32'(bus.wr_en),    32'd0);
        check({tag, "_waddr"}, bus.wr_addr,       32'd0);
        check({tag, "_wdata"}, bus.wr_data,       32'd0);
        check({tag, "_cpu"},   32'(cpu_rst_n),    32'd0);
        check({tag, "_busy"},  32'(busy),         32'd0);
        check({tag, "_done"},  32'(done),         32'd0);
        check({tag, "_error"}, 32'(error),        32'd0);
        step();
    endtask

    initial begin
        int k;
        bit hit;
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        ready_drops  = 0;
        repeat (2) step();
        rst_n = 1'b1;
        check_reset_outputs("reset");

        // Single word
        frame = '{8'h01, 8'h00, 8'h13, 8'h02, 8'hA0, 8'h00, 8'hB6};
        run_case("one_word", 0, -1);

        // RUN is sticky; presented bytes are not consumed
        got_a.delete();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("run_rdy", 32'(bus.rx_ready), 32'd0);
            step();
        end
        bus.rx_valid = 1'b0;
        check("run_nwr", 32'(got_a.size()), 32'd0);
        check("run_done", 32'(done), 32'd1);

        // Two words back to back, valid held high
        frame = '{8'h02, 8'h00, 8'h13, 8'h02, 8'hA0, 8'h00,
                  8'h63, 8'h0E, 8'h02, 8'h00};
        begin
            logic [7:0] s;
            s = 8'd0;
            foreach (frame[i]) s += frame[i];
            frame.push_back(s);
        end
        ready_drops = 0;
        run_case("two_words", 0, -1);
        check("two_words_ready_drops", 32'(ready_drops), 32'd0);

        // Bad checksum, oversize count, zero count
        frame = '{8'h01, 8'h00, 8'h13, 8'h02, 8'hA0, 8'h00, 8'hB7};
        run_case("bad_csum", 0, -1);
        frame = '{8'h2C, 8'h01};
        run_case("n300", 0, -1);
        frame = '{8'h00, 8'h00};
        run_case("n0", 0, -1);
        frame = '{8'h01, 8'h01};
        run_case("n257", 1, -1);

        // Largest legal frame
        build(256, 0);
        run_case("n256", 0, -1);

        // Timeout: error exactly 16 cycles after the last accept
        got_a.delete();
        pulse_start();
        frame = '{8'h01, 8'h00, 8'h13};
        send_frame(0, -1);
        k   = 0;
        hit = 0;
        while (!hit && k < 40) begin
            step();
            k++;
            @(negedge clk);
            hit = error;
        end
        check("tmo_cycles", 32'(k), 32'd16);
        check("tmo_nwr", 32'(got_a.size()), 32'd0);
        check("tmo_cpu", 32'(cpu_rst_n), 32'd0);
        step();

        // Reset after the second data byte of a word
        got_a.delete();
        pulse_start();
        frame = '{8'h01, 8'h00, 8'h13, 8'h02};
        send_frame(0, -1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset_outputs("mid_rst");
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA0;
        repeat (6) step();
        bus.rx_valid = 1'b0;
        check("mid_rst_nwr", 32'(got_a.size()), 32'd0);
        frame = '{8'h01, 8'h00, 8'h13, 8'h02, 8'hA0, 8'h00, 8'hB6};
        run_case("after_rst", 0, -1);

        // Randomized frames, some corrupt, some with a start pulse mid-data
        for (int t = 0; t < 24; t++) begin
            int n;
            int sa;
            n = int'($urandom_range(6, 1));
            build(n, $urandom_range(3, 0) == 0);
            sa = ($urandom_range(1, 0) == 1) ?
                 int'($urandom_range(4 * n + 1, 2)) : -1;
            run_case($sformatf("rnd%0d", t), 3, sa);
        end

        // Randomized illegal counts
        for (int t = 0; t < 4; t++) begin
            logic [15:0] n;
            n = (t == 0) ? 16'd0 : 16'($urandom_range(65535, 257));
            frame.delete();
            frame.push_back(n[7:0]);
            frame.push_back(n[15:8]);
            run_case($sformatf("badn%0d", t), 2, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
